// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store stage driving word-aligned requests to the memory controller
module lsu_mem_port #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_wen;
  logic [2:0]      lat_funct3;
  logic [1:0]      lat_off;

  logic            req_err;
  logic [31:0]     st_wdata;
  logic [7:0]      st_wmask;
  logic [31:0]     ld_word;
  logic [31:0]     ld_result;

  // Decode the offered op: legality check, lane-shifted store data and byte mask
  always_comb begin
    req_err  = 1'b0;
    st_wmask = 8'h00;
    st_wdata = in_wdata << {in_addr[1:0], 3'b000};
    case (in_funct3)
      3'b000: st_wmask = {4'b0000, 4'b0001 << in_addr[1:0]};
      3'b001: begin
        req_err  = in_addr[0];
        st_wmask = {4'b0000, 4'b0011 << in_addr[1:0]};
      end
      3'b010: begin
        req_err  = |in_addr[1:0];
        st_wmask = {4'b0000, 4'b1111 << in_addr[1:0]};
      end
      3'b100:  req_err = in_wen;
      3'b101:  req_err = in_wen | in_addr[0];
      default: req_err = 1'b1;
    endcase
    if (!in_wen) begin
      st_wmask = 8'h00;
      st_wdata = 32'h0;
    end
  end

  // Align the returned word to lane 0 and extend according to the load size
  always_comb begin
    ld_word   = mem_rdata >> {lat_off, 3'b000};
    ld_result = ld_word;
    case (lat_funct3)
      3'b000:  ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b100:  ld_result = {24'h0, ld_word[7:0]};
      3'b001:  ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b101:  ld_result = {16'h0, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  // Single-op FSM; every output is registered so mem_* cannot glitch during ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_wen    <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      in_ready   <= 1'b1;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_raddr  <= 32'h0;
      mem_waddr  <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 8'h00;
      out_valid  <= 1'b0;
      out_rdata  <= 32'h0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lat_wen    <= in_wen;
            lat_funct3 <= in_funct3;
            lat_off    <= in_addr[1:0];
            in_ready   <= 1'b0;
            if (req_err) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= 32'h0;
            end else begin
              state     <= ACCESS;
              cnt       <= CW'(MEM_LATENCY - 1);
              mem_valid <= 1'b1;
              mem_wen   <= in_wen;
              mem_raddr <= {in_addr[31:2], 2'b00};
              mem_waddr <= {in_addr[31:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wmask <= st_wmask;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_raddr <= 32'h0;
            mem_waddr <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wmask <= 8'h00;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= lat_wen ? 32'h0 : ld_result;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_rdata <= 32'h0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed vector bench for lsu_mem_port at latencies 1 and 3
module tb_lsu_mem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_wen, out_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, mem_rdata;

  logic        a_in_ready, a_mem_valid, a_mem_wen, a_out_valid, a_out_err;
  logic [31:0] a_mem_raddr, a_mem_waddr, a_mem_wdata, a_out_rdata;
  logic [7:0]  a_mem_wmask;
  logic        b_in_ready, b_mem_valid, b_mem_wen, b_out_valid, b_out_err;
  logic [31:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_out_rdata;
  logic [7:0]  b_mem_wmask;

  lsu_mem_port #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_wen(in_wen), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_valid(a_mem_valid), .mem_wen(a_mem_wen), .mem_raddr(a_mem_raddr),
    .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_rdata(mem_rdata), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_rdata(a_out_rdata), .out_err(a_out_err)
  );

  lsu_mem_port #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_wen(in_wen), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_raddr(b_mem_raddr),
    .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_rdata(mem_rdata), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_rdata(b_out_rdata), .out_err(b_out_err)
  );

  // Observe one instance at a time
  logic        sel;
  logic        s_in_ready, s_mem_valid, s_mem_wen, s_out_valid, s_out_err;
  logic [31:0] s_mem_raddr, s_mem_waddr, s_mem_wdata, s_out_rdata;
  logic [7:0]  s_mem_wmask;
  assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign s_mem_valid = sel ? b_mem_valid : a_mem_valid;
  assign s_mem_wen   = sel ? b_mem_wen   : a_mem_wen;
  assign s_mem_raddr = sel ? b_mem_raddr : a_mem_raddr;
  assign s_mem_waddr = sel ? b_mem_waddr : a_mem_waddr;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_mem_wmask = sel ? b_mem_wmask : a_mem_wmask;
  assign s_out_valid = sel ? b_out_valid : a_out_valid;
  assign s_out_rdata = sel ? b_out_rdata : a_out_rdata;
  assign s_out_err   = sel ? b_out_err   : a_out_err;

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [7:0]  ewmask;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs[14];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_reset_state();
    check("rst_in_ready",  {31'h0, s_in_ready},  32'h1);
    check("rst_mem_valid", {31'h0, s_mem_valid}, 32'h0);
    check("rst_out_valid", {31'h0, s_out_valid}, 32'h0);
    check("rst_out_rdata", s_out_rdata,          32'h0);
    check("rst_out_err",   {31'h0, s_out_err},   32'h0);
    check("rst_mem_wmask", {24'h0, s_mem_wmask}, 32'h0);
  endtask

  // Issue one op, track the memory pulse and response, optionally stall writeback
  task automatic do_op(input vec_t v, input int lat, input int hold);
    int          mem_cnt;
    int          lat_seen;
    logic        stable;
    logic [31:0] f_raddr, f_waddr, f_wdata;
    logic [7:0]  f_wmask;
    logic        f_wen;
    mem_cnt = 0; lat_seen = 0; stable = 1'b1;
    f_raddr = '0; f_waddr = '0; f_wdata = '0; f_wmask = '0; f_wen = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'h0, s_in_ready}, 32'h1);
    in_valid = 1'b1; in_wen = v.wen; in_funct3 = v.f3; in_addr = v.addr;
    in_wdata = v.wdata; mem_rdata = v.rdata; out_ready = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (s_out_valid) begin
        lat_seen = c;
        break;
      end
      if (s_mem_valid) begin
        if (mem_cnt == 0) begin
          f_raddr = s_mem_raddr; f_waddr = s_mem_waddr; f_wdata = s_mem_wdata;
          f_wmask = s_mem_wmask; f_wen = s_mem_wen;
        end else if (f_raddr !== s_mem_raddr || f_waddr !== s_mem_waddr ||
                     f_wdata !== s_mem_wdata || f_wmask !== s_mem_wmask ||
                     f_wen !== s_mem_wen) begin
          stable = 1'b0;
        end
        mem_cnt++;
      end
    end
    check("latency", lat_seen, v.err ? 32'd1 : 32'(lat + 1));
    check("mem_pulses", mem_cnt, v.err ? 32'd0 : 32'(lat));
    if (!v.err) begin
      check("mem_raddr", f_raddr, v.eaddr);
      check("mem_waddr", f_waddr, v.eaddr);
      check("mem_wen", {31'h0, f_wen}, {31'h0, v.wen});
      check("mem_stable", {31'h0, stable}, 32'h1);
      if (v.wen) begin
        check("mem_wdata", f_wdata, v.ewdata);
        check("mem_wmask", {24'h0, f_wmask}, {24'h0, v.ewmask});
      end
    end
    check("out_err", {31'h0, s_out_err}, {31'h0, v.err});
    check("out_rdata", s_out_rdata, v.erdata);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", {31'h0, s_out_valid}, 32'h1);
      check("hold_out_rdata", s_out_rdata, v.erdata);
      check("hold_in_ready", {31'h0, s_in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", {31'h0, s_out_valid}, 32'h0);
    check("post_in_ready", {31'h0, s_in_ready}, 32'h1);
  endtask

  initial begin
    vec_t lw;
    //          wen   f3      addr          wdata         rdata         err   eaddr         ewdata        ewmask erdata
    vecs[0]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h8000_0004, 32'h0,        8'h00, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h8312_3456, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'hFFFF_FF83};
    vecs[2]  = '{1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'h8312_3456, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_0083};
    vecs[3]  = '{1'b0, 3'b101, 32'h8000_0002, 32'h0,        32'h8312_3456, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_8312};
    vecs[4]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h8312_3456, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'hFFFF_8312};
    vecs[5]  = '{1'b0, 3'b000, 32'h8000_0001, 32'h0,        32'h0000_8000, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'hFFFF_FF80};
    vecs[6]  = '{1'b0, 3'b001, 32'h8000_0000, 32'h0,        32'hFFFF_7FFF, 1'b0, 32'h8000_0000, 32'h0,        8'h00, 32'h0000_7FFF};
    vecs[7]  = '{1'b1, 3'b001, 32'h8000_0102, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 32'h8000_0100, 32'hABCD_0000, 8'h0C, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,        1'b0, 32'h8000_0000, 32'h0000_A500, 8'h02, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h8000_0010, 32'h1122_3344, 32'h0,        1'b0, 32'h8000_0010, 32'h1122_3344, 8'h0F, 32'h0};
    vecs[10] = '{1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h0,        32'h0,        8'h00, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h8000_0001, 32'h1234_ABCD, 32'h0,        1'b1, 32'h0,        32'h0,        8'h00, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h8000_0000, 32'h0000_00FF, 32'h0,        1'b1, 32'h0,        32'h0,        8'h00, 32'h0};
    vecs[13] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h0,        32'h0,        8'h00, 32'h0};

    sel = 1'b0; reset = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'b000;
    in_addr = '0; in_wdata = '0; mem_rdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) do_op(vecs[i], 1, 0);

    sel = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    lw = '{1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678, 1'b0, 32'h8000_0008, 32'h0, 8'h00, 32'h1234_5678};
    do_op(lw, 3, 5);

    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_acc1", {31'h0, s_mem_valid}, 32'h1);
    @(negedge clk);
    check("rst_mid_acc2", {31'h0, s_mem_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_mem_valid", {31'h0, s_mem_valid}, 32'h0);
    check("rst_mid_in_ready",  {31'h0, s_in_ready},  32'h1);
    check("rst_mid_out_valid", {31'h0, s_out_valid}, 32'h0);

    lw = '{1'b0, 3'b010, 32'h8000_0030, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h8000_0030, 32'h0, 8'h00, 32'hCAFE_F00D};
    do_op(lw, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit stage directly upstream of the DPI memory controller.
- Accepts one memory op from execute via valid/ready and drives word-aligned read/write requests with byte-lane wmask and lane-shifted wdata.
- Holds each request stable for a fixed number of cycles, captures read data, and extracts and sign/zero-extends loads.
- Returns the result to writeback through a valid/ready response port.

Parameters:
- MEM_LATENCY, 1, cycles mem_valid is held per access (>=1); rdata is sampled in the last cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute offers an op.
- in_ready  out  1  stage can accept an op.
- in_wen  in  1  1 = store, 0 = load.
- in_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, right-aligned.
- mem_valid  out  1  request to memory controller.
- mem_wen  out  1  write enable to memory controller.
- mem_raddr  out  32  word-aligned read address.
- mem_waddr  out  32  word-aligned write address.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  8  byte mask; bits [7:4] always 0.
- mem_rdata  in  32  read word from memory controller.
- out_valid  out  1  response ready for writeback.
- out_ready  in  1  writeback accepts the response.
- out_rdata  out  32  extended load result; 0 for stores and errors.
- out_err  out  1  misaligned access or illegal funct3.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset value: IDLE.
- Reset values: all outputs 0 except in_ready = 1; internal registers and counter are cleared.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch wen, funct3, addr and wdata.
  - Misaligned (H with addr[0] = 1, W with addr[1:0] != 0) or illegal funct3 (011, 11x, or 1xx with wen = 1): go to RESP with out_err = 1. No memory request is issued.
  - Otherwise go to ACCESS with counter = MEM_LATENCY-1.
- ACCESS:
  - in_ready = 0; mem_valid = 1; mem_wen = latched wen.
  - mem_raddr = mem_waddr = {addr[31:2], 2'b00}.
  - All mem_* outputs are registered and must stay constant for the whole state. The downstream controller is level/edge sensitive, so any glitch causes a duplicate write.
  - Counter decrements each cycle. When it reaches 0: for a load, register the extracted result from mem_rdata; then go to RESP.
- Store encoding (sh = addr[1:0]*8):
  - mem_wdata = in_wdata << sh.
  - wmask = 0001/0011/1111 for B/H/W, shifted left by addr[1:0].
- Load extraction: word = mem_rdata >> sh.
  - B: sign-extend word[7:0]; BU: zero-extend word[7:0].
  - H: sign-extend word[15:0]; HU: zero-extend word[15:0].
  - W: word unchanged.
- Outside ACCESS: mem_valid, mem_wen, mem_wdata and mem_wmask are 0; addresses are 0.
- RESP:
  - out_valid = 1; out_rdata and out_err are held stable until out_ready.
  - On out_ready: go to IDLE, clear out_valid.
  - No new op is accepted in the same cycle; the stage has exactly one op in flight.
- Latency:
  - Accept to out_valid is MEM_LATENCY+1 cycles for a legal access.
  - Accept to out_valid is 1 cycle for an error.
- out_ready asserted before out_valid has no effect.
- Reset mid-operation: return to IDLE and drop mem_valid in the next cycle; the in-flight op is abandoned with no response. A store interrupted in ACCESS may already have been committed by memory.

Test Plan:
- LW addr 0x8000_0004, mem_rdata 0xDEAD_BEEF, MEM_LATENCY = 1 -> mem_raddr 0x8000_0004, mem_valid high exactly 1 cycle; out_valid 2 cycles after accept; out_rdata 0xDEAD_BEEF, out_err 0.
- LB addr 0x8000_0003, mem_rdata 0x8312_3456 -> out_rdata 0xFFFF_FF83. LBU same stimulus -> 0x0000_0083. LHU addr 0x8000_0002 -> 0x0000_8312.
- SH addr 0x8000_0102, wdata 0x1234_ABCD -> mem_waddr 0x8000_0100, mem_wdata 0xABCD_0000, mem_wmask 0x0C, mem_wen 1; out_rdata 0.
- LW addr 0x8000_0002 and SH addr 0x8000_0001 -> no mem_valid pulse; out_valid 1 cycle after accept; out_err 1. Same result for SB with funct3 100.
- MEM_LATENCY = 3, out_ready held low 5 cycles -> mem_valid high exactly 3 cycles with constant mem_* outputs; out_valid and out_rdata stable for all 5 cycles; in_ready 0 until the cycle after the out_ready handshake.
- Reset asserted in the second ACCESS cycle (MEM_LATENCY = 3) -> next cycle mem_valid 0, in_ready 1, out_valid 0; a following LW completes normally.
